equiv_vector_checker: RTL

- Sequential test driver and response checker for our equivalence-checking flow.
- Generates every input vector for two combinational gate-level netlists wired in parallel: golden (A) and candidate (B), e.g. test circuit pair 0000/0001.
- Waits a programmable settle time per vector, compares the two output buses, and reports equivalence plus the first failing vector.
- Sits on the other side of the circuit-under-test interface: it drives the I* inputs and observes the O* outputs.

---
 rtl/equiv_vector_checker_if.sv | 28 ++
 rtl/equiv_vector_checker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/equiv_vector_checker_if.sv
// Bundle between the equivalence checker and the circuit pair under test.
// master = checker side (drives vectors and results), slave = environment side.
interface equiv_vector_checker_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 2
);
  logic              start;
  logic [N_IN-1:0]   vec_out;
  logic [N_OUT-1:0]  resp_a;
  logic [N_OUT-1:0]  resp_b;
  logic              busy;
  logic              done;
  logic              equiv;
  logic [N_IN:0]     fail_count;
  logic [N_IN-1:0]   mismatch_vec;
  logic [N_OUT-1:0]  mismatch_a;
  logic [N_OUT-1:0]  mismatch_b;

  modport master (
    input  start, resp_a, resp_b,
    output vec_out, busy, done, equiv, fail_count, mismatch_vec, mismatch_a, mismatch_b
  );

  modport slave (
    output start, resp_a, resp_b,
    input  vec_out, busy, done, equiv, fail_count, mismatch_vec, mismatch_a, mismatch_b
  );
endinterface

// File: rtl/equiv_vector_checker.sv
// Exhaustive vector sweep over two parallel combinational netlists, comparing their
// outputs after a settle delay and recording the first failing vector.
module equiv_vector_checker #(
  parameter int unsigned N_IN         = 2,
  parameter int unsigned N_OUT        = 2,
  parameter int unsigned SETTLE       = 1,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  equiv_vector_checker_if.master bus
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StWait, StCmp, StDone} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [N_IN:0]      fail_q, fail_d;
  logic [N_IN-1:0]    mvec_q, mvec_d;
  logic [N_OUT-1:0]   ma_q, ma_d;
  logic [N_OUT-1:0]   mb_q, mb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               equiv_q, equiv_d;
  logic               mismatch;

  assign mismatch = (bus.resp_a != bus.resp_b);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    mvec_d  = mvec_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    equiv_d = equiv_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          vec_d   = '0;
          fail_d  = '0;
          mvec_d  = '0;
          ma_d    = '0;
          mb_d    = '0;
          equiv_d = 1'b0;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StCmp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCmp: begin
        if (mismatch) begin
          fail_d = fail_q + 1'b1;
          if (fail_q == '0) begin
            mvec_d = vec_q;
            ma_d   = bus.resp_a;
            mb_d   = bus.resp_b;
          end
        end
        if (mismatch && STOP_ON_FAIL) begin
          equiv_d = 1'b0;
          state_d = StDone;
        end else if (&vec_q) begin
          // Judge on the count including this final comparison.
          equiv_d = (fail_d == '0);
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWait) || (state_d == StCmp);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      fail_q  <= '0;
      mvec_q  <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      mvec_q  <= mvec_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equiv_q <= equiv_d;
    end
  end

  assign bus.vec_out      = vec_q;
  assign bus.fail_count   = fail_q;
  assign bus.mismatch_vec = mvec_q;
  assign bus.mismatch_a   = ma_q;
  assign bus.mismatch_b   = mb_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.equiv        = equiv_q;

endmodule
